// File: rtl/epmp_ibus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : epmp_ibus_arbiter_if
// Purpose  : Bundles the IBH bus request/grant signals shared between the
//            tristate sources and the IBH round-robin arbiter.
// Signals  : req     - per-source bus request (source index = bit position)
//            gnt     - one-hot registered grant / source output-enable
//            owner   - binary index of the current grantee (valid while busy)
//            busy    - high exactly when some gnt bit is high
//            timeout - one-cycle pulse on a watchdog-forced release
// Modports : master - the bus sources (drive req, observe grant status)
//            slave  - the arbiter (samples req, drives grant status)
// Revision : 1.0 - initial release
// ============================================================================
interface epmp_ibus_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [2:0]      owner;
    logic            busy;
    logic            timeout;

    modport master (
        output req,
        input  gnt,
        input  owner,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output owner,
        output busy,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/epmp_ibus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : epmp_ibus_arbiter
// Purpose  : Round-robin arbiter/sequencer for the EPMP internal high-byte
//            bus (IBH). Issues one-hot registered grants that drive each
//            source's output-enable, with a mandatory one-cycle turnaround
//            between successive owners.
// Ports    : clk  - system clock, all state changes on posedge
//            rst  - asynchronous, active-high reset
//            ibus - epmp_ibus_arbiter_if.slave (req in; gnt/owner/busy/timeout
//                   out, all registered)
// Params   : NREQ     - number of bus sources (2..8)
//            HOLD_MAX - max GRANT cycles per tenure (1..15), watchdog only
// Options  : EPMP_IBUS_TIMEOUT_EN - when defined, a hold watchdog forces
//            release after HOLD_MAX cycles and pulses timeout; when undefined
//            tenure is unbounded and timeout is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module epmp_ibus_arbiter #(
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    epmp_ibus_arbiter_if.slave  ibus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // One extra bit so pointer + offset can exceed NREQ before wrapping.
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [2:0]      owner_q, owner_d;
    logic            busy_q, busy_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [CW-1:0]   cand;
    logic            owner_req;

`ifdef EPMP_IBUS_TIMEOUT_EN
    logic [3:0]      hold_q, hold_d;
    logic            timeout_q, timeout_d;
`endif

    // Round-robin search: first set request at or after the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!win_found && ibus.req[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    assign owner_req = ibus.req[owner_q[PW-1:0]];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
`ifdef EPMP_IBUS_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            // IDLE and TURN arbitrate identically; TURN only exists so the
            // bus sees one undriven cycle between owners.
            S_IDLE, S_TURN: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    gnt_d   = NREQ'(1) << win_idx;
                    owner_d = 3'(win_idx);
                    busy_d  = 1'b1;
                    ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
`ifdef EPMP_IBUS_TIMEOUT_EN
                    hold_d  = 4'd1;
`endif
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            S_GRANT: begin
                if (!owner_req) begin
                    state_d = S_TURN;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
`ifdef EPMP_IBUS_TIMEOUT_EN
                else if (hold_q == 4'(HOLD_MAX)) begin
                    state_d   = S_TURN;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else if (hold_q != 4'hF) begin
                    hold_d = hold_q + 4'd1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            owner_q   <= 3'd0;
            busy_q    <= 1'b0;
            ptr_q     <= '0;
`ifdef EPMP_IBUS_TIMEOUT_EN
            hold_q    <= 4'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
`ifdef EPMP_IBUS_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign ibus.gnt   = gnt_q;
    assign ibus.owner = owner_q;
    assign ibus.busy  = busy_q;
`ifdef EPMP_IBUS_TIMEOUT_EN
    assign ibus.timeout = timeout_q;
`else
    assign ibus.timeout = 1'b0;
`endif

endmodule
`default_nettype wire
